// File: rtl/time_set_ctrl.sv
// Time-setting controller: turns debounced mode/inc/dec levels into an edit session
// that freezes the time counters, steps hours then minutes, and ends with a load strobe.
module time_set_ctrl #(
  parameter int HOURS_MAX    = 24,
  parameter int MINUTES_MAX  = 60,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_mode,
  input  logic                           btn_inc,
  input  logic                           btn_dec,
  input  logic [$clog2(HOURS_MAX):0]     cur_hours,
  input  logic [$clog2(MINUTES_MAX):0]   cur_minutes,
  output logic                           run_en,
  output logic                           load_new_time,
  output logic                           clear_seconds,
  output logic [$clog2(HOURS_MAX):0]     new_hours,
  output logic [$clog2(MINUTES_MAX):0]   new_minutes,
  output logic                           editing_hours,
  output logic                           editing_minutes
);

  localparam int HW      = $clog2(HOURS_MAX) + 1;
  localparam int MW      = $clog2(MINUTES_MAX) + 1;
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_mode_prev, r_inc_prev, r_dec_prev;
  logic [CW-1:0]   r_inc_cnt, r_dec_cnt;
  logic            r_inc_rep, r_dec_rep;
  logic [HW-1:0]   r_hours, w_hours_nxt;
  logic [MW-1:0]   r_minutes, w_minutes_nxt;
  logic            r_run_en, r_load, r_clr, r_edit_hr, r_edit_min;
  logic            w_run_en_nxt, w_load_nxt, w_edit_hr_nxt, w_edit_min_nxt;
  logic            w_mode_press, w_inc_press, w_dec_press;
  logic            w_step_ok, w_inc_fire, w_dec_fire, w_inc_step, w_dec_step;
  logic [CW-1:0]   w_inc_lim, w_dec_lim;
  logic [CW:0]     w_inc_hold_nxt, w_dec_hold_nxt;

  // Hold-counter update: {repeating, count}; count 0 means idle until the next press.
  function automatic logic [CW:0] hold_next(input logic          active,
                                            input logic          press,
                                            input logic          fire,
                                            input logic [CW-1:0] cnt,
                                            input logic          rep);
    logic [CW:0] res;
    res = {(CW+1){1'b0}};
    if (active) begin
      if (press) begin
        res = {1'b0, CW'(1)};
      end else if (fire) begin
        res = {1'b1, CW'(1)};
      end else if (cnt != {CW{1'b0}}) begin
        res = {rep, cnt + CW'(1)};
      end else begin
        res = {(CW+1){1'b0}};
      end
    end else begin
      res = {(CW+1){1'b0}};
    end
    return res;
  endfunction

  function automatic logic [HW-1:0] hr_step(input logic [HW-1:0] v, input logic up);
    if (up) return (v >= HW'(HOURS_MAX - 1)) ? {HW{1'b0}} : v + HW'(1);
    else    return (v == {HW{1'b0}} || v >= HW'(HOURS_MAX)) ? HW'(HOURS_MAX - 1) : v - HW'(1);
  endfunction

  function automatic logic [MW-1:0] min_step(input logic [MW-1:0] v, input logic up);
    if (up) return (v >= MW'(MINUTES_MAX - 1)) ? {MW{1'b0}} : v + MW'(1);
    else    return (v == {MW{1'b0}} || v >= MW'(MINUTES_MAX)) ? MW'(MINUTES_MAX - 1) : v - MW'(1);
  endfunction

  assign w_mode_press = btn_mode & ~r_mode_prev;
  assign w_inc_press  = btn_inc & ~r_inc_prev;
  assign w_dec_press  = btn_dec & ~r_dec_prev;

  // Step sources: press step plus auto-repeat while one step button is held alone.
  always_comb begin
    w_step_ok      = (r_state != ST_RUN) & ~w_mode_press & ~(btn_inc & btn_dec);
    w_inc_lim      = r_inc_rep ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY);
    w_dec_lim      = r_dec_rep ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY);
    w_inc_fire     = btn_inc & ~w_inc_press & (r_inc_cnt != {CW{1'b0}}) & (r_inc_cnt == w_inc_lim);
    w_dec_fire     = btn_dec & ~w_dec_press & (r_dec_cnt != {CW{1'b0}}) & (r_dec_cnt == w_dec_lim);
    w_inc_step     = w_step_ok & (w_inc_press | w_inc_fire);
    w_dec_step     = w_step_ok & (w_dec_press | w_dec_fire);
    w_inc_hold_nxt = hold_next(w_step_ok & btn_inc, w_inc_press, w_inc_fire, r_inc_cnt, r_inc_rep);
    w_dec_hold_nxt = hold_next(w_step_ok & btn_dec, w_dec_press, w_dec_fire, r_dec_cnt, r_dec_rep);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: mode press cycles RUN -> SET_HR -> SET_MIN -> RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     w_state_nxt = w_mode_press ? ST_SET_HR  : ST_RUN;
      ST_SET_HR:  w_state_nxt = w_mode_press ? ST_SET_MIN : ST_SET_HR;
      ST_SET_MIN: w_state_nxt = w_mode_press ? ST_RUN     : ST_SET_MIN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // Output logic: next values of the registered outputs and edit registers.
  always_comb begin
    w_run_en_nxt   = (w_state_nxt == ST_RUN);
    w_edit_hr_nxt  = (w_state_nxt == ST_SET_HR);
    w_edit_min_nxt = (w_state_nxt == ST_SET_MIN);
    w_load_nxt     = (r_state == ST_SET_MIN) & w_mode_press;
    w_hours_nxt    = r_hours;
    w_minutes_nxt  = r_minutes;
    case (r_state)
      ST_RUN: begin
        if (w_mode_press) begin
          w_hours_nxt   = (cur_hours < HW'(HOURS_MAX)) ? cur_hours : {HW{1'b0}};
          w_minutes_nxt = (cur_minutes < MW'(MINUTES_MAX)) ? cur_minutes : {MW{1'b0}};
        end else begin
          w_hours_nxt   = r_hours;
          w_minutes_nxt = r_minutes;
        end
      end
      ST_SET_HR: begin
        if (w_inc_step | w_dec_step) begin
          w_hours_nxt = hr_step(r_hours, w_inc_step);
        end else begin
          w_hours_nxt = r_hours;
        end
      end
      ST_SET_MIN: begin
        if (w_inc_step | w_dec_step) begin
          w_minutes_nxt = min_step(r_minutes, w_inc_step);
        end else begin
          w_minutes_nxt = r_minutes;
        end
      end
      default: begin
        w_hours_nxt   = r_hours;
        w_minutes_nxt = r_minutes;
      end
    endcase
  end

  // Output, edit, press-history and hold-counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode_prev <= 1'b0;
      r_inc_prev  <= 1'b0;
      r_dec_prev  <= 1'b0;
      r_inc_cnt   <= {CW{1'b0}};
      r_dec_cnt   <= {CW{1'b0}};
      r_inc_rep   <= 1'b0;
      r_dec_rep   <= 1'b0;
      r_hours     <= {HW{1'b0}};
      r_minutes   <= {MW{1'b0}};
      r_run_en    <= 1'b1;
      r_load      <= 1'b0;
      r_clr       <= 1'b0;
      r_edit_hr   <= 1'b0;
      r_edit_min  <= 1'b0;
    end else begin
      r_mode_prev <= btn_mode;
      r_inc_prev  <= btn_inc;
      r_dec_prev  <= btn_dec;
      {r_inc_rep, r_inc_cnt} <= w_inc_hold_nxt;
      {r_dec_rep, r_dec_cnt} <= w_dec_hold_nxt;
      r_hours     <= w_hours_nxt;
      r_minutes   <= w_minutes_nxt;
      r_run_en    <= w_run_en_nxt;
      r_load      <= w_load_nxt;
      r_clr       <= w_load_nxt;
      r_edit_hr   <= w_edit_hr_nxt;
      r_edit_min  <= w_edit_min_nxt;
    end
  end

  assign run_en          = r_run_en;
  assign load_new_time   = r_load;
  assign clear_seconds   = r_clr;
  assign new_hours       = r_hours;
  assign new_minutes     = r_minutes;
  assign editing_hours   = r_edit_hr;
  assign editing_minutes = r_edit_min;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Table-driven bench for time_set_ctrl plus hand-written auto-repeat and load-strobe sequences.
module tb_time_set_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_mode, btn_inc, btn_dec;
  logic [5:0] cur_hours;
  logic [6:0] cur_minutes;
  logic       run_en, load_new_time, clear_seconds, editing_hours, editing_minutes;
  logic [5:0] new_hours;
  logic [6:0] new_minutes;

  int n_pass  = 0;
  int n_total = 0;

  time_set_ctrl #(
    .HOURS_MAX(24), .MINUTES_MAX(60), .REPEAT_DELAY(8), .REPEAT_RATE(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .run_en(run_en),
    .load_new_time(load_new_time), .clear_seconds(clear_seconds),
    .new_hours(new_hours), .new_minutes(new_minutes),
    .editing_hours(editing_hours), .editing_minutes(editing_minutes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r, mo, in, de;
    int   ch, cm;
    logic run, ld;
    int   h, m;
    logic eh, em;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input logic r, mo, in, de, input int ch, cm,
                              input logic run, ld, input int h, m, input logic eh, em);
    vec_t v;
    v.r = r; v.mo = mo; v.in = in; v.de = de; v.ch = ch; v.cm = cm;
    v.run = run; v.ld = ld; v.h = h; v.m = m; v.eh = eh; v.em = em;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit after the rising edge.
  task automatic drive(input logic r, mo, in, de, input int ch, cm);
    @(negedge clk);
    rst = r; btn_mode = mo; btn_inc = in; btn_dec = de;
    cur_hours = 6'(ch); cur_minutes = 7'(cm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_m;
    int loads;
    int load_idx;
    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cur_hours = 6'd0; cur_minutes = 7'd0;

    //            r  mo in de  ch  cm   run ld  h   m  eh em
    vecs[0]  = mk(0, 0, 0, 0, 13, 45,   1, 0,  0,  0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 13, 45,   1, 0,  0,  0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 13, 45,   0, 0, 13, 45, 1, 0);
    vecs[3]  = mk(1, 0, 0, 0, 13, 45,   0, 0, 13, 45, 1, 0);
    vecs[4]  = mk(1, 0, 1, 0, 13, 45,   0, 0, 14, 45, 1, 0);
    vecs[5]  = mk(1, 0, 0, 0, 13, 45,   0, 0, 14, 45, 1, 0);
    vecs[6]  = mk(1, 0, 0, 1, 13, 45,   0, 0, 13, 45, 1, 0);
    vecs[7]  = mk(1, 0, 0, 0, 13, 45,   0, 0, 13, 45, 1, 0);
    vecs[8]  = mk(1, 1, 1, 0, 13, 45,   0, 0, 13, 45, 0, 1);
    vecs[9]  = mk(1, 0, 0, 0, 13, 45,   0, 0, 13, 45, 0, 1);
    vecs[10] = mk(1, 0, 1, 1, 13, 45,   0, 0, 13, 45, 0, 1);
    vecs[11] = mk(1, 0, 0, 0, 13, 45,   0, 0, 13, 45, 0, 1);
    vecs[12] = mk(1, 0, 0, 1, 13, 45,   0, 0, 13, 44, 0, 1);
    vecs[13] = mk(1, 0, 0, 0, 13, 45,   0, 0, 13, 44, 0, 1);
    vecs[14] = mk(1, 1, 0, 0, 13, 45,   1, 1, 13, 44, 0, 0);
    vecs[15] = mk(1, 0, 0, 0, 13, 45,   1, 0, 13, 44, 0, 0);
    vecs[16] = mk(1, 1, 0, 0,  0, 70,   0, 0,  0,  0, 1, 0);
    vecs[17] = mk(1, 0, 0, 0,  0, 70,   0, 0,  0,  0, 1, 0);
    vecs[18] = mk(1, 0, 0, 1,  0, 70,   0, 0, 23,  0, 1, 0);
    vecs[19] = mk(1, 0, 0, 0,  0, 70,   0, 0, 23,  0, 1, 0);
    vecs[20] = mk(1, 0, 1, 0,  0, 70,   0, 0,  0,  0, 1, 0);
    vecs[21] = mk(1, 0, 0, 0,  0, 70,   0, 0,  0,  0, 1, 0);
    vecs[22] = mk(1, 1, 0, 0,  0, 70,   0, 0,  0,  0, 0, 1);
    vecs[23] = mk(1, 0, 0, 0,  0, 70,   0, 0,  0,  0, 0, 1);
    vecs[24] = mk(1, 0, 0, 1,  0, 70,   0, 0,  0, 59, 0, 1);
    vecs[25] = mk(1, 0, 0, 0,  0, 70,   0, 0,  0, 59, 0, 1);
    vecs[26] = mk(1, 0, 0, 1,  0, 70,   0, 0,  0, 58, 0, 1);
    vecs[27] = mk(1, 0, 0, 0,  0, 70,   0, 0,  0, 58, 0, 1);
    vecs[28] = mk(0, 0, 0, 0,  0, 70,   1, 0,  0,  0, 0, 0);
    vecs[29] = mk(0, 1, 0, 0, 22, 70,   1, 0,  0,  0, 0, 0);
    vecs[30] = mk(1, 1, 0, 0, 22, 70,   0, 0, 22,  0, 1, 0);
    vecs[31] = mk(0, 0, 0, 0, 22, 70,   1, 0,  0,  0, 0, 0);

    for (int i = 0; i < 32; i++) begin
      drive(vecs[i].r, vecs[i].mo, vecs[i].in, vecs[i].de, vecs[i].ch, vecs[i].cm);
      chk($sformatf("v%0d run_en", i), 32'(run_en), 32'(vecs[i].run));
      chk($sformatf("v%0d load", i), 32'(load_new_time), 32'(vecs[i].ld));
      chk($sformatf("v%0d clear_sec", i), 32'(clear_seconds), 32'(vecs[i].ld));
      chk($sformatf("v%0d new_hours", i), 32'(new_hours), 32'(vecs[i].h));
      chk($sformatf("v%0d new_minutes", i), 32'(new_minutes), 32'(vecs[i].m));
      chk($sformatf("v%0d edit_hr", i), 32'(editing_hours), 32'(vecs[i].eh));
      chk($sformatf("v%0d edit_min", i), 32'(editing_minutes), 32'(vecs[i].em));
    end

    // Auto-repeat: inc held 20 cycles from minutes=10, steps at P, P+8, P+11, P+14, P+17.
    drive(1, 0, 0, 0, 7, 10);
    drive(1, 1, 0, 0, 7, 10);
    drive(1, 0, 0, 0, 7, 10);
    drive(1, 1, 0, 0, 7, 10);
    drive(1, 0, 0, 0, 7, 10);
    chk("rep start min", 32'(new_minutes), 32'd10);
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 1, 0, 7, 10);
      exp_m = 11 + ((k >= 8) ? 1 : 0) + ((k >= 11) ? 1 : 0)
                 + ((k >= 14) ? 1 : 0) + ((k >= 17) ? 1 : 0);
      chk($sformatf("rep k%0d min", k), 32'(new_minutes), 32'(exp_m));
    end
    drive(1, 0, 0, 0, 7, 10);
    chk("rep final min", 32'(new_minutes), 32'd15);
    chk("rep final hr", 32'(new_hours), 32'd7);

    // Full edit cycle with 7/30: exactly one load cycle carrying 7/30 with run_en high.
    drive(0, 0, 0, 0, 7, 30);
    drive(1, 1, 0, 0, 7, 30);
    drive(1, 0, 0, 0, 7, 30);
    drive(1, 1, 0, 0, 7, 30);
    drive(1, 0, 0, 0, 7, 30);
    chk("pre-load run_en", 32'(run_en), 32'd0);
    loads = 0;
    load_idx = -1;
    for (int k = 0; k < 6; k++) begin
      drive(1, (k == 0) ? 1'b1 : 1'b0, 0, 0, 7, 30);
      if (load_new_time === 1'b1) begin
        loads++;
        load_idx = k;
        chk("load hours", 32'(new_hours), 32'd7);
        chk("load minutes", 32'(new_minutes), 32'd30);
        chk("load run_en", 32'(run_en), 32'd1);
        chk("load clear_sec", 32'(clear_seconds), 32'd1);
        chk("load edit_min", 32'(editing_minutes), 32'd0);
      end
    end
    chk("load count", 32'(loads), 32'd1);
    chk("load cycle", 32'(load_idx), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
